// File: rtl/mixer_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : mixer_i2s_tx
// Purpose  : Serialises 32-bit stereo mixer samples onto a Philips I2S bus
//            (BCLK, LRCLK, SDATA) using a programmable clock divider.
// Revision : 1.0 - initial release
// ============================================================================
module mixer_i2s_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] sample_in,
    input  logic        sample_in_vld,
    output logic        sample_in_rdy,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata,
    output logic        underrun
);

    localparam int                 c_div_w    = $clog2(CLK_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

    logic               r_run;
    logic [c_div_w-1:0] r_div_cnt;
    logic               r_bclk;
    logic               r_lrclk;
    logic               r_sdata;
    logic               r_underrun;
    logic [4:0]         r_slot;
    logic [31:0]        r_shift;
    logic [31:0]        r_buf;
    logic               r_buf_full;
    logic               r_started;

    logic               w_fall;
    logic               w_load;
    logic               w_xfer;
    logic [4:0]         w_slot_nxt;

    // A falling tick is the divider wrap that takes BCLK from 1 to 0.
    assign w_fall     = r_run & r_bclk & (r_div_cnt == c_div_last);
    assign w_load     = w_fall & (r_slot == 5'd0);
    assign w_slot_nxt = r_slot + 5'd1;
    assign w_xfer     = sample_in_vld & sample_in_rdy;

    assign sample_in_rdy = r_run & ~r_buf_full;
    assign i2s_bclk      = r_bclk;
    assign i2s_lrclk     = r_lrclk;
    assign i2s_sdata     = r_sdata;
    assign underrun      = r_underrun;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run      <= 1'b0;
            r_div_cnt  <= '0;
            r_bclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
            r_slot     <= 5'd0;
            r_shift    <= 32'd0;
            r_buf      <= 32'd0;
            r_buf_full <= 1'b0;
            r_started  <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_underrun <= 1'b0;

            if (r_run) begin
                if (r_div_cnt == c_div_last) begin
                    r_div_cnt <= '0;
                    r_bclk    <= ~r_bclk;
                end else begin
                    r_div_cnt <= r_div_cnt + 1'b1;
                end
            end

            if (w_fall) begin
                r_slot  <= w_slot_nxt;
                r_lrclk <= w_slot_nxt[4];
                if (w_load) begin
                    // Left word goes out first, so it lands in the upper half.
                    if (r_buf_full) begin
                        r_shift <= {r_buf[15:0], r_buf[31:16]};
                        r_sdata <= r_buf[15];
                    end else begin
                        r_shift    <= 32'd0;
                        r_sdata    <= 1'b0;
                        r_underrun <= r_started;
                    end
                end else begin
                    r_shift <= {r_shift[30:0], 1'b0};
                    r_sdata <= r_shift[30];
                end
            end

            // Transfers only happen with the buffer empty, so they never
            // coincide with a buffer-full load.
            if (w_xfer) begin
                r_buf      <= sample_in;
                r_buf_full <= 1'b1;
                r_started  <= 1'b1;
            end else if (w_load && r_buf_full) begin
                r_buf_full <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mixer_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mixer_i2s_tx
// Purpose  : Self-checking bench for mixer_i2s_tx against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mixer_i2s_tx;

    localparam int D     = 2;
    localparam int FRAME = 64 * D;
    localparam int NF    = 64;

    logic        clk           = 1'b0;
    logic        reset         = 1'b0;
    logic [31:0] sample_in     = 32'd0;
    logic        sample_in_vld = 1'b0;
    logic        sample_in_rdy;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic        underrun;

    mixer_i2s_tx #(.CLK_DIV(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_in     (sample_in),
        .sample_in_vld (sample_in_vld),
        .sample_in_rdy (sample_in_rdy),
        .i2s_bclk      (i2s_bclk),
        .i2s_lrclk     (i2s_lrclk),
        .i2s_sdata     (i2s_sdata),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          k = -1;          // clk edges since run was set; -1 = not running
    int          first_xfer = -1; // edge index of the first accepted sample
    logic [31:0] f_data [NF];     // sample carried by each frame
    bit          f_has  [NF];
    logic [31:0] pat;

    // Edge index of the load tick that starts frame f.
    function automatic int kl(input int f);
        return 2 * D * (32 * f + 1);
    endfunction

    // First frame whose load tick lies strictly after edge kk.
    function automatic int next_frame(input int kk);
        if (kk < kl(0)) return 0;
        return (kk - kl(0)) / FRAME + 1;
    endfunction

    function automatic bit m_rdy();
        return (k >= 0) && !f_has[next_frame(k)];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NF; i++) begin
            f_has[i]  = 1'b0;
            f_data[i] = 32'd0;
        end
        k          = -1;
        first_xfer = -1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at k=%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        logic        e_bclk;
        logic        e_lr;
        logic        e_sd;
        logic        e_ur;
        int          j;
        int          f;
        int          p;
        logic [31:0] w;
        e_bclk = 1'b0;
        e_lr   = 1'b0;
        e_sd   = 1'b0;
        e_ur   = 1'b0;
        if (k >= 0) begin
            e_bclk = ((k / D) % 2) == 1;
            j      = k / (2 * D);
            e_lr   = (j % 32) >= 16;
            if (j > 0) begin
                f    = (j - 1) / 32;
                p    = (j - 1) % 32;
                w    = f_has[f] ? {f_data[f][15:0], f_data[f][31:16]} : 32'd0;
                e_sd = w[31-p];
            end
            if (k >= kl(0) && ((k - kl(0)) % FRAME) == 0) begin
                f    = (k - kl(0)) / FRAME;
                e_ur = !f_has[f] && first_xfer >= 0 && first_xfer < k;
            end
        end
        chk("bclk",     32'(i2s_bclk),      32'(e_bclk));
        chk("lrclk",    32'(i2s_lrclk),     32'(e_lr));
        chk("sdata",    32'(i2s_sdata),     32'(e_sd));
        chk("underrun", 32'(underrun),      32'(e_ur));
        chk("rdy",      32'(sample_in_rdy), 32'(m_rdy()));
    endtask

    // One clk: inputs are already set; model updates on the edge, check at negedge.
    task automatic tick(output bit x);
        int f;
        x = sample_in_vld && m_rdy();
        @(posedge clk);
        if (reset) k++;
        if (x) begin
            f         = next_frame(k);
            f_has[f]  = 1'b1;
            f_data[f] = sample_in;
            if (first_xfer < 0) first_xfer = k;
        end
        @(negedge clk);
        check_all();
    endtask

    // mode 0 idle, 1 back-to-back incrementing, 2 sparse random
    task automatic run(input int n, input int mode);
        bit x;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: sample_in_vld = 1'b0;
                1: begin
                    sample_in_vld = 1'b1;
                    sample_in     = pat;
                end
                default: begin
                    sample_in_vld = ($urandom_range(0, 199) == 0);
                    sample_in     = $urandom;
                end
            endcase
            tick(x);
            if (x && mode == 1) pat = pat + 32'h0001_0001;
        end
        sample_in_vld = 1'b0;
    endtask

    task automatic run_until(input int target, input int mode);
        if (target > k) run(target - k, mode);
    endtask

    task automatic send_one(input logic [31:0] data);
        bit x;
        bit got;
        got = 1'b0;
        sample_in     = data;
        sample_in_vld = 1'b1;
        for (int i = 0; i < 2 * FRAME && !got; i++) begin
            tick(x);
            got = x;
        end
        sample_in_vld = 1'b0;
        if (!got) chk("xfer_timeout", 32'(got), 32'd1);
    endtask

    initial begin
        bit x;
        clear_model();
        pat = 32'h0001_0000;

        // Reset held, then idle after release.
        reset = 1'b0;
        run(5, 0);
        reset = 1'b1;
        run_until(2 * FRAME + 20, 0);

        // Single sample, then idle frames produce underrun pulses.
        send_one(32'h8001_A5C3);
        run_until(kl(6) + 10, 0);

        // Back-to-back stream, then starve the buffer.
        run(8 * FRAME, 1);
        run(3 * FRAME + 20, 0);

        // Collision: sample arrives on the very edge of an empty load tick.
        run_until(kl(next_frame(k)) - 1, 0);
        sample_in     = 32'h1234_5678;
        sample_in_vld = 1'b1;
        tick(x);
        sample_in_vld = 1'b0;
        run(2 * FRAME + 10, 0);

        // Sparse random traffic.
        run(6 * FRAME, 2);

        // Reset at slot 10 with a sample buffered.
        run(FRAME, 1);
        for (int i = 0; i < FRAME && ((k / (2 * D)) % 32) != 10; i++) run(1, 1);
        reset = 1'b0;
        #1;
        chk("rst_bclk",     32'(i2s_bclk),      32'd0);
        chk("rst_lrclk",    32'(i2s_lrclk),     32'd0);
        chk("rst_sdata",    32'(i2s_sdata),     32'd0);
        chk("rst_underrun", 32'(underrun),      32'd0);
        chk("rst_rdy",      32'(sample_in_rdy), 32'd0);
        clear_model();
        run(3, 0);
        reset = 1'b1;
        run_until(2 * FRAME + 20, 0);
        send_one(32'hCAFE_1234);
        run(2 * FRAME, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
